// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation encodings plus multiply sequencer state and latency
package alu_pkg;
  typedef enum logic [3:0] {
    C_ADD_U, C_SUB_U, C_AND, C_OR, C_XOR, C_NOR, C_SLT, C_SLTU,
    C_SLL, C_SRL, C_SRA, C_LUI, C_MULT, C_MUL_U, C_MFHI, C_MFLO
  } alu_sel_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mult_state_t;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_LAT = MULT_WIDTH + 1;
endpackage

// File: rtl/mult_hilo_seq.sv
// mult_hilo_seq: radix-2 shift-add multiply sequencer owning architectural HI/LO
module mult_hilo_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  alu_sel_t         alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_result,
  output logic             mf_stall
);
  localparam int CW = $clog2(WIDTH + 1);
  mult_state_t        r_state, w_next;
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_prod;
  logic [WIDTH-1:0]   r_mplier, r_hi, r_lo, w_abs_a, w_abs_b;
  logic [CW-1:0]      r_cnt;
  logic               r_neg, r_done, w_signed, w_accept, w_mf;
  always_comb begin
    w_signed = alu_sel == C_MULT;
    w_accept = req & (r_state == IDLE) & (w_signed | (alu_sel == C_MUL_U));
    w_abs_a  = (w_signed & a[WIDTH-1]) ? -a : a;
    w_abs_b  = (w_signed & b[WIDTH-1]) ? -b : b;
    w_prod   = r_neg ? -r_acc : r_acc;
    w_next   = r_state;
    w_next   = (r_state == IDLE) ? (w_accept ? RUN : IDLE) :
               (r_state == RUN)  ? ((r_cnt == CW'(1)) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == FIX;
      if (w_accept) begin
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
        r_mplier <= w_abs_b;
        r_neg    <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_cnt    <= CW'(WIDTH);
      end else if (r_state == RUN) begin
        r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - 1'b1;
      end
      if (r_state == FIX) {r_hi, r_lo} <= w_prod;
    end
  end
  always_comb begin
    w_mf      = (alu_sel == C_MFHI) | (alu_sel == C_MFLO);
    ready     = r_state == IDLE;
    busy      = r_state != IDLE;
    done      = r_done;
    hi        = r_hi;
    lo        = r_lo;
    mf_stall  = busy & w_mf;
    mf_result = (alu_sel == C_MFHI) ? r_hi : (alu_sel == C_MFLO) ? r_lo : '0;
  end
endmodule

// File: tb/tb_mult_hilo_seq.sv
// tb_mult_hilo_seq: random and directed multiplies checked every cycle against a behavioural HI/LO model
module tb_mult_hilo_seq;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, req = 0;
  alu_sel_t alu_sel = C_ADD_U;
  logic [W-1:0] a = '0, b = '0;
  logic ready, busy, done, mf_stall;
  logic [W-1:0] hi, lo, mf_result;
  int checks = 0, failures = 0, cyc = 0, t_acc = 0, t_done = 0, t1 = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [2*W-1:0] m_prod = '0;
  logic m_done = 0;
  int m_left = 0;
  bit mf_poke = 0;

  mult_hilo_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .alu_sel(alu_sel), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .mf_result(mf_result), .mf_stall(mf_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact 64-bit product from plain arithmetic, published WIDTH+1 edges after accept
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_prod;
          m_done = 1;
        end
      end else if (req && (alu_sel == C_MULT || alu_sel == C_MUL_U)) begin
        m_prod = (alu_sel == C_MULT) ? 64'($signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}))
                                     : {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m_left = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", ready, m_left == 0);
    chk("busy", busy, m_left != 0);
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("mf_stall", mf_stall, (m_left != 0) && (alu_sel == C_MFHI || alu_sel == C_MFLO));
    chk("mf_result", mf_result, alu_sel == C_MFHI ? m_hi : alu_sel == C_MFLO ? m_lo : '0);
  end

  task automatic issue(input alu_sel_t s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    req = 1; alu_sel = s; a = x; b = y;
    for (int n = 0; n < 200 && !ready; n++) @(negedge clk);
    @(posedge clk);
    #1 req = 0;
    @(negedge clk);
    t_acc = cyc;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mf_poke) alu_sel = alu_sel_t'($urandom_range(0, 15));
      if (done) break;
    end
    if (n == 100) chk("done_timeout", 0, 1);
    t_done = cyc;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] c [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    return ($urandom_range(0, 2) == 0) ? c[$urandom_range(0, 4)] : W'($urandom);
  endfunction

  initial begin
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_hilo", {hi, lo}, 0);
    #20 rst_n = 1;
    @(negedge clk);
    req = 1; alu_sel = C_ADD_U;
    repeat (5) @(negedge clk);
    chk("ignored_req_busy", busy, 0);
    req = 0;

    issue(C_MUL_U, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    chk("umax_latency", t_done - t_acc, 33);
    chk("umax_hi", hi, 32'hFFFFFFFE);
    chk("umax_lo", lo, 32'h00000001);
    @(negedge clk);
    chk("done_single", done, 0);

    issue(C_MULT, 32'hFFFFFFFF, 32'h2);
    wait_done();
    chk("neg_prod", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    issue(C_MULT, 32'h80000000, 32'h80000000);
    wait_done();
    chk("minint_sq", {hi, lo}, 64'h40000000_00000000);

    issue(C_MUL_U, 32'h10000, 32'h30000);
    repeat (4) @(negedge clk);
    alu_sel = C_MFHI;
    @(negedge clk);
    chk("mf_stall_busy", mf_stall, 1);
    chk("mf_old_hi", mf_result, 32'h40000000);
    wait_done();
    chk("mf_done_stall", mf_stall, 0);
    chk("mf_new_hi", mf_result, 32'h3);

    issue(C_MULT, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_hilo", {hi, lo}, 0);
    @(negedge clk);
    #2 rst_n = 1;
    issue(C_MUL_U, 6, 7);
    wait_done();
    chk("post_rst_lo", lo, 42);

    @(negedge clk);
    req = 1; alu_sel = C_ADD_U; a = 3; b = 5;
    repeat (3) @(negedge clk);
    chk("add_no_accept", busy, 0);
    alu_sel = C_MUL_U;
    @(posedge clk);
    @(negedge clk);
    a = 7; b = 0;
    @(negedge clk);
    chk("held_no_ready", ready, 0);
    wait_done();
    t1 = t_done;
    chk("b2b_first_lo", lo, 15);
    @(negedge clk);
    chk("b2b_accepted", busy, 1);
    req = 0;
    wait_done();
    chk("b2b_gap", t_done - t1, 34);
    chk("b2b_second", {hi, lo}, 0);

    for (int i = 0; i < 25; i++) begin
      issue($urandom_range(0, 1) ? C_MULT : C_MUL_U, pick(), pick());
      mf_poke = 1;
      wait_done();
      mf_poke = 0;
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_hilo_seq.md
# mult_hilo_seq

Multi-cycle multiply sequencer and HI/LO register owner for the MIPS datapath. It accepts C_MULT / C_MUL_U requests from the main controller and runs a radix-2 shift-add multiply over WIDTH cycles. The product is written into architectural HI/LO. It serves C_MFHI / C_MFLO reads, and stalls them while a multiply is in flight. The single-cycle ALU is unaffected; this block sits beside it and shares alu_sel_t.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  multiply request; valid only with alu_sel ∈ {C_MULT, C_MUL_U}.
- alu_sel  in  alu_sel_t  operation select; also qualifies mf_result and mf_stall.
- a, b  in  WIDTH  operands; sampled only on the accept edge.
- ready  out  1  high in IDLE only.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; HI/LO hold the new product in the same cycle.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- mf_result  out  WIDTH  combinational: hi for C_MFHI, lo for C_MFLO, 0 otherwise.
- mf_stall  out  1  combinational: busy & alu_sel ∈ {C_MFHI, C_MFLO}.

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE → RUN** on the accept condition req & ready & alu_sel ∈ {C_MULT, C_MUL_U}.
  - Latch |a| and |b| (magnitudes for C_MULT, raw values for C_MUL_U).
  - Latch neg = a[WIDTH-1]^b[WIDTH-1] for C_MULT, 0 for C_MUL_U.
  - Clear the 2·WIDTH accumulator; load cnt = WIDTH.
- **req with any other alu_sel** is ignored: no state change, no error.
- **RUN:** each cycle, if multiplier LSB = 1, add the shifted multiplicand into the accumulator; shift the multiplier right and the multiplicand left; decrement cnt. When cnt reaches 1, go to FIX.
- **FIX:** write {hi, lo} = neg ? −acc : acc (2·WIDTH two's complement), pulse done, go to IDLE.
- **Arithmetic:** magnitudes are WIDTH-bit unsigned, so |−2^(WIDTH−1)| = 2^(WIDTH−1) is exact; the accumulator never overflows 2·WIDTH bits.
- **Early termination:** none. Zero operands still take full latency.
- **Requester handshake:** the requester holds req/alu_sel/a/b until it sees ready; the block never queues requests.
- **HI/LO write rule:** HI/LO change only in FIX and on reset; a multiply in flight leaves the old HI/LO readable.
- **Reads while busy:** C_MFHI/C_MFLO still drive mf_result from the old HI/LO, but mf_stall = 1. The controller must hold the instruction until mf_stall drops.

## Timing
- **Reset (rst_n low, any state, takes effect immediately):**
  - state = IDLE.
  - hi = lo = 0, done = 0, busy = 0, ready = 1.
  - Accumulator and cnt cleared.
- **Reset mid-multiply:** the operation is abandoned; HI/LO read 0, not the partial product.
- **Latency:**
  - Accept edge E: busy = 1 after E.
  - RUN occupies WIDTH cycles.
  - FIX edge E+WIDTH+1: HI/LO updated, done = 1 for that cycle, ready = 1.
  - Total: WIDTH+1 edges from accept to result (33 for WIDTH = 32).
- **Back-to-back:** a new request may be accepted at the edge following the done cycle. Issue rate is one multiply per WIDTH+2 cycles.
- **Same-cycle MF read in the done cycle:** mf_stall = 0 and mf_result returns the new value.
- **done** is registered; never high for two consecutive cycles.

## Structure
- alu_pkg is the shared package and supplies alu_sel_t; this block imports it and redefines no encodings.
- Add mult_state_t (IDLE, RUN, FIX) to alu_pkg so the controller and bench can observe state symbolically.
- Add a derived constant MULT_LAT = WIDTH+1 to alu_pkg for controller scoreboarding.
- No sub-module: the datapath (accumulator, shift registers, counter, negate) and the HI/LO pair are in one module.

## Test plan
- **Unsigned max:** C_MUL_U, a = b = 0xFFFFFFFF → after 33 edges, hi = 0xFFFFFFFE, lo = 0x00000001, done pulses once.
- **Signed mixed:** C_MULT, a = 0xFFFFFFFF (−1), b = 0x00000002 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. Also C_MULT, a = b = 0x80000000 → hi = 0x40000000, lo = 0x00000000.
- **MF stall:** C_MFHI presented 5 cycles after accept → mf_stall = 1 and mf_result = old hi until the done cycle, then the new hi with mf_stall = 0.
- **Reset mid-op:** rst_n low at cycle 10 of RUN → immediately busy = 0, ready = 1, hi = lo = 0. A request after release completes normally.
- **Back-to-back with ignored request:**
  - req held with C_ADD_U in IDLE → no accept.
  - Two C_MUL_U requests (3×5, then 7×0) → first done gives lo = 15.
  - Second is accepted the edge after done and completes 34 edges after the first done with lo = 0, hi = 0.
- **Request while busy:** req held during RUN → ready = 0, no re-latch of a/b; the held request is accepted only after done.
